// File: rtl/exe_mem_stage_pkg.sv
// Shared core definitions for the EXE/MEM pipeline boundary.
// Provides the byte-enable width, the hard-wired zero register address,
// the reset-active level, the occupancy state encoding of the skid buffer
// and a helper that sizes the packed EXE->MEM payload.
package exe_mem_stage_pkg;

  localparam int   MEM_BE_W   = 4;     // store byte-enable width
  localparam int   REG_ZERO   = 0;     // architectural x0, never written
  localparam logic RST_ACTIVE = 1'b0;  // resets are active-low

  // Occupancy of the two-entry (main + skid) buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_e;

  // Packed payload: wt_data, wt_addr, wt_en, is_load, is_store, mem_be, st_data.
  function automatic int payload_w(input int data_w, input int addr_w);
    return 2 * data_w + addr_w + 3 + MEM_BE_W;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry pipeline register with skid slot.
// The output is always taken from the main entry; the skid entry absorbs one
// extra beat so that in_ready depends only on the registered state, never
// combinationally on out_ready. flush discards all held entries.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous squash, highest priority
//   in_valid/in_ready     upstream handshake, in_data payload
//   out_valid/out_ready   downstream handshake, out_data payload
module pipe_skid_buf
  import exe_mem_stage_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  occ_e         state, state_nxt;
  logic [W-1:0] main_q, skid_q;
  logic         load_main, load_skid, shift_skid;
  logic         accept, drain;

  // Both handshake outputs are decoded straight from the state flop.
  assign in_ready  = (state != ST_TWO);
  assign out_valid = (state != ST_EMPTY);
  assign out_data  = main_q;

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    load_main  = 1'b0;
    load_skid  = 1'b0;
    shift_skid = 1'b0;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (accept) begin
            state_nxt = ST_ONE;
            load_main = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            load_main = 1'b1;
          end else if (accept) begin
            state_nxt = ST_TWO;
            load_skid = 1'b1;
          end else if (drain) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only a drain can occur.
          if (drain) begin
            state_nxt  = ST_ONE;
            shift_skid = 1'b1;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n == RST_ACTIVE) state <= ST_EMPTY;
    else                     state <= state_nxt;
  end

  // NOTE: the payload entries are reset too, because the outputs must read
  // zero while in reset; only two entries, so this is not a memory array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n == RST_ACTIVE) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main)       main_q <= in_data;
      else if (shift_skid) main_q <= skid_q;
      if (load_skid)       skid_q <= in_data;
    end
  end

endmodule

// File: rtl/exe_mem_stage.sv
// EXE -> MEM pipeline stage.
// Packs the EXE result into a two-entry skid buffer, suppresses writes to
// the zero register, exposes a forwarding tap for the hazard unit (ALU
// results only; load data does not exist yet at this point) and counts
// cycles of MEM back-pressure in a saturating counter.
// Ports:
//   clk_i_EXE_MEM_STAGE, rst_i_EXE_MEM_STAGE   clock, async active-low reset
//   flush_i                                   squash all held entries
//   in_valid_i/in_ready_o + payload inputs     EXE-side handshake
//   out_valid_o/out_ready_i + out_*_o          MEM-side handshake
//   fwd_valid_o, fwd_addr_o, fwd_data_o        forwarding tap
//   stall_cnt_o                                back-pressure cycle count
module exe_mem_stage
  import exe_mem_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic                clk_i_EXE_MEM_STAGE,
  input  logic                rst_i_EXE_MEM_STAGE,
  input  logic                flush_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [DATA_W-1:0]   wt_data,
  input  logic [ADDR_W-1:0]   wt_addr,
  input  logic                wt_en,
  input  logic                is_load,
  input  logic                is_store,
  input  logic [MEM_BE_W-1:0] mem_be,
  input  logic [DATA_W-1:0]   st_data,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [DATA_W-1:0]   out_wt_data_o,
  output logic [ADDR_W-1:0]   out_wt_addr_o,
  output logic                out_wt_en_o,
  output logic                out_is_load_o,
  output logic                out_is_store_o,
  output logic [MEM_BE_W-1:0] out_mem_be_o,
  output logic [DATA_W-1:0]   out_st_data_o,
  output logic                fwd_valid_o,
  output logic [ADDR_W-1:0]   fwd_addr_o,
  output logic [DATA_W-1:0]   fwd_data_o,
  output logic [CNT_W-1:0]    stall_cnt_o
);

  localparam int PAY_W = payload_w(DATA_W, ADDR_W);

  logic [PAY_W-1:0] in_pay, out_pay;
  logic             wt_en_gated;

  // x0 is hard-wired to zero: drop the write enable when it is targeted.
  assign wt_en_gated = wt_en & (wt_addr != ADDR_W'(REG_ZERO));

  assign in_pay = {wt_data, wt_addr, wt_en_gated, is_load, is_store, mem_be, st_data};

  pipe_skid_buf #(.W(PAY_W)) u_buf (
    .clk       (clk_i_EXE_MEM_STAGE),
    .rst_n     (rst_i_EXE_MEM_STAGE),
    .flush     (flush_i),
    .in_valid  (in_valid_i),
    .in_ready  (in_ready_o),
    .in_data   (in_pay),
    .out_valid (out_valid_o),
    .out_ready (out_ready_i),
    .out_data  (out_pay)
  );

  assign {out_wt_data_o, out_wt_addr_o, out_wt_en_o, out_is_load_o,
          out_is_store_o, out_mem_be_o, out_st_data_o} = out_pay;

  assign fwd_valid_o = out_valid_o & out_wt_en_o & ~out_is_load_o;
  assign fwd_addr_o  = out_wt_addr_o;
  assign fwd_data_o  = out_wt_data_o;

  // Saturating back-pressure counter; flush deliberately leaves it alone.
  always_ff @(posedge clk_i_EXE_MEM_STAGE or negedge rst_i_EXE_MEM_STAGE) begin
    if (rst_i_EXE_MEM_STAGE == RST_ACTIVE) begin
      stall_cnt_o <= '0;
    end else if (out_valid_o && !out_ready_i && (stall_cnt_o != {CNT_W{1'b1}})) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_exe_mem_stage.sv
module tb_exe_mem_stage;
  import exe_mem_stage_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                flush_i, in_valid_i, in_ready_o;
  logic [DATA_W-1:0]   wt_data, st_data;
  logic [ADDR_W-1:0]   wt_addr;
  logic                wt_en, is_load, is_store;
  logic [MEM_BE_W-1:0] mem_be;
  logic                out_valid_o, out_ready_i;
  logic [DATA_W-1:0]   out_wt_data_o, out_st_data_o;
  logic [ADDR_W-1:0]   out_wt_addr_o;
  logic                out_wt_en_o, out_is_load_o, out_is_store_o;
  logic [MEM_BE_W-1:0] out_mem_be_o;
  logic                fwd_valid_o;
  logic [ADDR_W-1:0]   fwd_addr_o;
  logic [DATA_W-1:0]   fwd_data_o;
  logic [CNT_W-1:0]    stall_cnt_o;

  always #5 clk = ~clk;

  exe_mem_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk_i_EXE_MEM_STAGE (clk),
    .rst_i_EXE_MEM_STAGE (rst_n),
    .flush_i             (flush_i),
    .in_valid_i          (in_valid_i),
    .in_ready_o          (in_ready_o),
    .wt_data             (wt_data),
    .wt_addr             (wt_addr),
    .wt_en               (wt_en),
    .is_load             (is_load),
    .is_store            (is_store),
    .mem_be              (mem_be),
    .st_data             (st_data),
    .out_valid_o         (out_valid_o),
    .out_ready_i         (out_ready_i),
    .out_wt_data_o       (out_wt_data_o),
    .out_wt_addr_o       (out_wt_addr_o),
    .out_wt_en_o         (out_wt_en_o),
    .out_is_load_o       (out_is_load_o),
    .out_is_store_o      (out_is_store_o),
    .out_mem_be_o        (out_mem_be_o),
    .out_st_data_o       (out_st_data_o),
    .fwd_valid_o         (fwd_valid_o),
    .fwd_addr_o          (fwd_addr_o),
    .fwd_data_o          (fwd_data_o),
    .stall_cnt_o         (stall_cnt_o)
  );

  typedef struct packed {
    logic [DATA_W-1:0]   wt_data;
    logic [ADDR_W-1:0]   wt_addr;
    logic                wt_en;
    logic                is_load;
    logic                is_store;
    logic [MEM_BE_W-1:0] mem_be;
    logic [DATA_W-1:0]   st_data;
  } pay_t;

  typedef struct {
    pay_t       stim;
    logic       exp_fwd_valid;
    logic       exp_wt_en;
  } vec_t;

  pay_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input pay_t p);
    wt_data  = p.wt_data;
    wt_addr  = p.wt_addr;
    wt_en    = p.wt_en;
    is_load  = p.is_load;
    is_store = p.is_store;
    mem_be   = p.mem_be;
    st_data  = p.st_data;
  endtask

  function automatic pay_t mk(input logic [31:0] d, input logic [4:0] a, input logic en);
    pay_t p;
    p = '0;
    p.wt_data = d;
    p.wt_addr = a;
    p.wt_en   = en;
    return p;
  endfunction

  // Scoreboard: expected entries are pushed as the handshake accepts them
  // (with the zero-register rule applied) and popped as MEM drains them.
  always @(negedge clk) begin
    pay_t e, got;
    if (rst_n) begin
      if (flush_i) begin
        sb_q.delete();
      end else begin
        if (out_valid_o && out_ready_i) begin
          if (sb_q.size() == 0) begin
            check("sb_unexpected_output", 1, 0);
          end else begin
            e   = sb_q.pop_front();
            got = {out_wt_data_o, out_wt_addr_o, out_wt_en_o, out_is_load_o,
                   out_is_store_o, out_mem_be_o, out_st_data_o};
            check("sb_payload", got, e);
          end
        end
        if (in_valid_i && in_ready_o) begin
          e = {wt_data, wt_addr, wt_en && (wt_addr != 0), is_load, is_store, mem_be, st_data};
          sb_q.push_back(e);
        end
      end
    end
  end

  vec_t         vecs[5];
  logic [31:0]  got_q[$];
  bit           acc;
  int           exp_cnt;
  pay_t         tmp;

  initial begin
    flush_i = 0; in_valid_i = 0; out_ready_i = 0;
    drive('0);

    // Vector table: ALU write, load, x0 target, store without write, ALU write.
    vecs[0] = '{mk(32'h1234_5678, 5'd5, 1'b1), 1'b1, 1'b1};
    tmp = mk(32'hAAAA_5555, 5'd7, 1'b1); tmp.is_load = 1'b1;
    vecs[1] = '{tmp, 1'b0, 1'b1};
    vecs[2] = '{mk(32'hDEAD_BEEF, 5'd0, 1'b1), 1'b0, 1'b0};
    tmp = mk(32'h0000_00FF, 5'd31, 1'b0); tmp.is_store = 1'b1;
    tmp.mem_be = 4'b0011; tmp.st_data = 32'hCAFE_F00D;
    vecs[3] = '{tmp, 1'b0, 1'b0};
    vecs[4] = '{mk(32'h8000_0001, 5'd1, 1'b1), 1'b1, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid_o, 0);
    check("rst_in_ready", in_ready_o, 1);
    check("rst_fwd_valid", fwd_valid_o, 0);
    check("rst_stall_cnt", stall_cnt_o, 0);
    check("rst_payload", {out_wt_data_o, out_wt_addr_o, out_wt_en_o, out_is_load_o,
                          out_is_store_o, out_mem_be_o, out_st_data_o}, 0);
    @(negedge clk) rst_n = 1;
    step();

    // Streaming vectors with MEM always ready: one-cycle latency each.
    out_ready_i = 1;
    for (int i = 0; i < 5; i++) begin
      drive(vecs[i].stim);
      in_valid_i = 1;
      step();
      check($sformatf("vec%0d_out_valid", i), out_valid_o, 1);
      check($sformatf("vec%0d_fwd_valid", i), fwd_valid_o, vecs[i].exp_fwd_valid);
      check($sformatf("vec%0d_fwd_addr", i), fwd_addr_o, vecs[i].stim.wt_addr);
      check($sformatf("vec%0d_fwd_data", i), fwd_data_o, vecs[i].stim.wt_data);
      check($sformatf("vec%0d_wt_en", i), out_wt_en_o, vecs[i].exp_wt_en);
    end
    in_valid_i = 0;
    step();
    check("stream_drained", out_valid_o, 0);
    check("stream_sb_empty", sb_q.size(), 0);

    // Back-pressure: A, B fill both entries, C must wait, order preserved.
    out_ready_i = 0;
    drive(mk(32'h1, 5'd1, 1'b1)); in_valid_i = 1;
    step();
    check("bp_ready_one", in_ready_o, 1);
    drive(mk(32'h2, 5'd2, 1'b1));
    step();
    check("bp_ready_full", in_ready_o, 0);
    drive(mk(32'h3, 5'd3, 1'b1));
    step();
    check("bp_c_blocked", in_ready_o, 0);
    check("bp_held_data", out_wt_data_o, 32'h1);
    out_ready_i = 1;
    for (int c = 0; c < 10 && got_q.size() < 3; c++) begin
      acc = in_valid_i && in_ready_o;
      if (out_valid_o && out_ready_i) got_q.push_back(out_wt_data_o);
      step();
      if (acc) in_valid_i = 0;
    end
    check("bp_count", got_q.size(), 3);
    for (int k = 0; k < got_q.size(); k++)
      check($sformatf("bp_order%0d", k), got_q[k], k + 1);
    check("bp_empty_after", out_valid_o, 0);

    // Flush in state TWO with same-cycle accept and drain.
    out_ready_i = 0;
    drive(mk(32'h10, 5'd4, 1'b1)); in_valid_i = 1;
    step();
    drive(mk(32'h20, 5'd4, 1'b1));
    step();
    check("fl_full", in_ready_o, 0);
    drive(mk(32'h30, 5'd4, 1'b1));
    flush_i = 1; out_ready_i = 1;
    step();
    flush_i = 0; in_valid_i = 0;
    check("fl_out_valid", out_valid_o, 0);
    check("fl_in_ready", in_ready_o, 1);
    step();
    check("fl_nothing_stored", out_valid_o, 0);
    check("fl_sb_empty", sb_q.size(), 0);

    // Reset while full.
    out_ready_i = 0;
    drive(mk(32'h40, 5'd6, 1'b1)); in_valid_i = 1;
    step();
    drive(mk(32'h50, 5'd6, 1'b1));
    step();
    in_valid_i = 0;
    step();
    check("mr_full_valid", out_valid_o, 1);
    #2 rst_n = 0;
    #1;
    check("mr_out_valid", out_valid_o, 0);
    check("mr_in_ready", in_ready_o, 1);
    check("mr_stall_cnt", stall_cnt_o, 0);
    check("mr_fwd_valid", fwd_valid_o, 0);
    check("mr_data", out_wt_data_o, 0);
    sb_q.delete();
    @(negedge clk) rst_n = 1;
    step();
    check("mr_idle", out_valid_o, 0);
    drive(mk(32'h77, 5'd9, 1'b1)); in_valid_i = 1;
    step();
    in_valid_i = 0;
    check("mr_first_valid", out_valid_o, 1);
    check("mr_first_data", out_wt_data_o, 32'h77);

    // Saturating stall counter over 20 stalled cycles.
    exp_cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
      check($sformatf("stall_cyc%0d", k), stall_cnt_o, exp_cnt);
    end
    check("stall_data_stable", out_wt_data_o, 32'h77);
    out_ready_i = 1;
    step();
    check("stall_drained", out_valid_o, 0);
    check("stall_hold", stall_cnt_o, 15);
    check("final_sb_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exe_mem_stage.md
EXE_MEM_STAGE -- requirements
Module: exe_mem_stage

Interface
REQ-001 The block SHALL take parameter DATA_W, default 32, as register/ALU data width.
REQ-002 The block SHALL take parameter ADDR_W, default 5, as register-file address width.
REQ-003 The block SHALL take parameter CNT_W, default 16, as stall-counter width.
REQ-004 The block SHALL have clk_i_EXE_MEM_STAGE, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have rst_i_EXE_MEM_STAGE, input, 1, reset that is asynchronous and active-low.
REQ-006 The block SHALL have flush_i, input, 1, synchronous squash of all held entries (branch/trap).
REQ-007 The block SHALL have in_valid_i, input, 1 and in_ready_o, output, 1, the EXE-side handshake.
REQ-008 The block SHALL have in payload inputs: wt_data DATA_W; wt_addr ADDR_W; wt_en 1; is_load 1; is_store 1; mem_be 4; st_data DATA_W.
REQ-009 The block SHALL have out_valid_o, output, 1 and out_ready_i, input, 1, the MEM-side handshake.
REQ-010 The block SHALL have out payload outputs mirroring REQ-008 (same names, _o suffix).
REQ-011 The block SHALL have fwd_valid_o 1, fwd_addr_o ADDR_W and fwd_data_o DATA_W, outputs, the forwarding tap for the hazard unit.
REQ-012 The block SHALL have stall_cnt_o, output, CNT_W, the saturating MEM back-pressure cycle count.

Function
REQ-013 Storage SHALL be two entries, main and skid; occupancy states are EMPTY, ONE (main only) and TWO (main+skid).
REQ-014 in_ready_o SHALL be registered and equal 1 exactly when state != TWO, so there is no combinational path from out_ready_i.
REQ-015 An input is accepted when in_valid_i and in_ready_o are both 1; out_valid_o SHALL be 1 exactly when state != EMPTY; out payload SHALL always come from main.
REQ-016 Transitions: EMPTY+accept->ONE (write main); ONE+accept+drain->ONE (main replaced); ONE+accept, no drain->TWO (write skid); ONE+drain, no accept->EMPTY; TWO+drain->ONE (skid moves to main); otherwise hold.
REQ-017 Latency SHALL be 1 cycle from accept to out_valid_o when EMPTY; ordering SHALL be strictly FIFO.
REQ-018 Held payload SHALL be stable while out_valid_o=1 and out_ready_i=0.
REQ-019 An accepted entry with wt_addr==0 SHALL be stored with wt_en=0.
REQ-020 flush_i SHALL take priority over every other event: next state EMPTY, and any same-cycle accept and drain is discarded; payload registers may retain stale values.
REQ-021 fwd_valid_o SHALL equal out_valid_o & out_wt_en_o & ~out_is_load_o; fwd_addr_o/fwd_data_o SHALL equal main wt_addr/wt_data; load data is not forwardable here.
REQ-022 stall_cnt_o SHALL increment by 1 in each cycle with out_valid_o=1 and out_ready_i=0, and saturate at 2^CNT_W-1; flush does not clear it.

Reset
REQ-023 On rst_i_EXE_MEM_STAGE=0, asynchronously: state EMPTY, in_ready_o=1, out_valid_o=0, all payload outputs 0, fwd_valid_o=0, stall_cnt_o=0.
REQ-024 Reset asserted mid-transfer SHALL drop all entries with no partial output; the first accept after deassertion behaves as from EMPTY.

Structure
REQ-025 Payload widths, mem_be width (4), register-zero address and reset-active level SHALL come from the shared core defines package, not local literals.
REQ-026 The two-entry storage and state machine SHALL be one sub-module, pipe_skid_buf, parametrised on total payload width; exe_mem_stage packs/unpacks fields and adds zero-register gating, forwarding and the stall counter.

Verification
REQ-027 Reset, then accept wt_data=0x12345678, wt_addr=5, wt_en=1 with out_ready_i=1 -> next cycle out_valid_o=1, fwd_valid_o=1, fwd_addr_o=5, fwd_data_o=0x12345678.
REQ-028 Hold out_ready_i=0, push A=0x1 then B=0x2 -> in_ready_o=0 after B; C=0x3 not accepted; release -> outputs A then B then C, no loss or duplication.
REQ-029 State TWO, assert flush_i with in_valid_i=1 and out_ready_i=1 -> next cycle out_valid_o=0, in_ready_o=1, nothing emitted or stored.
REQ-030 Accept is_load=1, wt_en=1, wt_addr=7 -> out_valid_o=1, fwd_valid_o=0; accept wt_addr=0, wt_en=1 -> out_wt_en_o=0.
REQ-031 CNT_W=4, out_valid_o=1 with out_ready_i=0 for 20 cycles -> stall_cnt_o reaches 15 and holds.
REQ-032 Assert reset while in state TWO -> immediately out_valid_o=0, stall_cnt_o=0; after release one accept yields out_valid_o=1 one cycle later.
